// File: rtl/minsoo_mitchell_encoder_k_if.sv
// Valid/ready operand and result channels of the Mitchell log encoder.
interface minsoo_mitchell_encoder_k_if #(
   parameter int N     = 8,
   parameter int LOG_N = 3,
   parameter int K     = 5
);
   logic                 in_valid;
   logic                 in_ready;
   logic [N-1:0]         x;
   logic                 out_valid;
   logic                 out_ready;
   logic [LOG_N+K-1:0]   log_out;
   logic                 zero;

   modport master (
      output in_valid, x, out_ready,
      input  in_ready, out_valid, log_out, zero
   );

   modport slave (
      input  in_valid, x, out_ready,
      output in_ready, out_valid, log_out, zero
   );
endinterface

// File: rtl/minsoo_mitchell_encoder_k.sv
// Two-stage Mitchell log2 approximation: stage 1 finds the leading one,
// stage 2 forms {characteristic, truncated mantissa}. Valid/ready on both sides.
module minsoo_mitchell_encoder_k #(
   parameter int N     = 8,
   parameter int LOG_N = 3,
   parameter int K     = 5
) (
   input  logic                        clk,
   input  logic                        rst_n,
   minsoo_mitchell_encoder_k_if.slave  bus
);
   logic                 r_s1_valid;
   logic [N-1:0]         r_s1_x;
   logic [LOG_N-1:0]     r_s1_pos;
   logic                 r_s1_zero;
   logic                 r_out_valid;
   logic [LOG_N+K-1:0]   r_log_out;
   logic                 r_zero;

   logic                 w_s2_adv;
   logic                 w_in_ready;
   logic [LOG_N-1:0]     w_pos;
   logic                 w_zero;
   logic [K-1:0]         w_mant;

   assign w_s2_adv   = !r_out_valid || bus.out_ready;
   // rst_n is folded in so the upstream sees not-ready during a reset cycle
   assign w_in_ready = rst_n && (!r_s1_valid || w_s2_adv);
   assign w_zero     = (bus.x == '0);

   always_comb begin
      w_pos = '0;
      for (int i = 0; i < N; i++) begin
         if (bus.x[i]) begin
            w_pos = LOG_N'(i);
         end
      end
   end

   // Bits below the leading one, MSB-first; positions past bit 0 stay zero
   always_comb begin
      int b;
      w_mant = '0;
      b      = 0;
      for (int j = 0; j < K; j++) begin
         b = int'(r_s1_pos) - 1 - j;
         if (b >= 0) begin
            w_mant[K-1-j] = r_s1_x[b];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_x      <= '0;
         r_s1_pos    <= '0;
         r_s1_zero   <= 1'b0;
         r_out_valid <= 1'b0;
         r_log_out   <= '0;
         r_zero      <= 1'b0;
      end else begin
         if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
               r_s1_x    <= bus.x;
               r_s1_pos  <= w_pos;
               r_s1_zero <= w_zero;
            end
         end
         if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_zero    <= r_s1_zero;
               r_log_out <= r_s1_zero ? '0 : {r_s1_pos, w_mant};
            end
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.log_out   = r_log_out;
   assign bus.zero      = r_zero;
endmodule

// File: tb/tb_minsoo_mitchell_encoder_k.sv
// Directed and randomized checks of the Mitchell encoder against hand values
// and an arithmetic reference model, with an order-preserving scoreboard.
module tb_minsoo_mitchell_encoder_k;
   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_bad;
   int   n_rx;

   minsoo_mitchell_encoder_k_if #(.N(8), .LOG_N(3), .K(5)) bus ();

   minsoo_mitchell_encoder_k #(.N(8), .LOG_N(3), .K(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Mitchell mantissa as the truncated fraction (x - 2^p) / 2^p scaled by 2^K
   function automatic logic [8:0] ref_model(input logic [7:0] v);
      int p;
      int frac;
      p = -1;
      for (int i = 0; i < 8; i++) if (v[i]) p = i;
      if (p < 0) return 9'h100;
      frac = ((int'(v) - (1 << p)) << 5) >> p;
      return {1'b0, 3'(p), 5'(frac)};
   endfunction

   logic [8:0] exp_q[$];
   logic       hold_valid;
   logic [8:0] hold_val;

   initial begin
      hold_valid = 1'b0;
      hold_val   = '0;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         hold_valid = 1'b0;
      end else begin
         if (hold_valid) begin
            check_eq("stall_hold", {22'd0, bus.out_valid, bus.zero, bus.log_out},
                     {22'd0, 1'b1, hold_val});
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_out", 32'd1, 32'd0);
            end else begin
               check_eq("scoreboard", {23'd0, bus.zero, bus.log_out}, {23'd0, exp_q.pop_front()});
               n_rx++;
            end
         end
         if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_model(bus.x));
         hold_valid = bus.out_valid && !bus.out_ready;
         hold_val   = {bus.zero, bus.log_out};
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic single(input logic [7:0] v, input logic [7:0] exp_log, input logic exp_zero);
      bus.in_valid  = 1'b1;
      bus.x         = v;
      bus.out_ready = 1'b1;
      #1;
      check_eq("single_in_ready", {31'd0, bus.in_ready}, 32'd1);
      step();
      bus.in_valid = 1'b0;
      bus.x        = ~v;
      check_eq("single_lat1_valid", {31'd0, bus.out_valid}, 32'd0);
      step();
      check_eq("single_valid", {31'd0, bus.out_valid}, 32'd1);
      check_eq("single_log", {24'd0, bus.log_out}, {24'd0, exp_log});
      check_eq("single_zero", {31'd0, bus.zero}, {31'd0, exp_zero});
      step();
      check_eq("single_drain", {31'd0, bus.out_valid}, 32'd0);
   endtask

   initial begin
      logic [7:0] vals[4];
      logic [7:0] exps[4];
      int idx;
      int oidx;
      int sent;
      int cyc;

      n_vec = 0;
      n_bad = 0;
      n_rx  = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b1;
      bus.x         = 8'h5A;
      bus.out_ready = 1'b1;

      // reset state
      step();
      step();
      check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check_eq("rst_log_out", {24'd0, bus.log_out}, 32'd0);
      check_eq("rst_zero", {31'd0, bus.zero}, 32'd0);
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      #1;
      check_eq("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      step();

      // hand-computed single operands
      single(8'b0110_1101, 8'b110_10110, 1'b0);
      single(8'h01, 8'b000_00000, 1'b0);
      single(8'hFF, 8'b111_11111, 1'b0);
      single(8'b0000_0110, 8'b010_10000, 1'b0);
      single(8'h00, 8'h00, 1'b1);
      single(8'h80, 8'b111_00000, 1'b0);
      single(8'h02, 8'b001_00000, 1'b0);

      // back-to-back stream with a 3-cycle downstream stall
      vals = '{8'd3, 8'd5, 8'd9, 8'd17};
      exps = '{8'b001_10000, 8'b010_01000, 8'b011_00100, 8'b100_00010};
      idx  = 0;
      oidx = 0;
      for (int k = 0; k < 20; k++) begin
         bus.out_ready = !(k >= 2 && k < 5);
         bus.in_valid  = (idx < 4);
         bus.x         = (idx < 4) ? vals[idx] : 8'hA5;
         #1;
         if (k == 2) check_eq("stream_in_ready_full", {31'd0, bus.in_ready}, 32'd0);
         if (bus.out_valid && bus.out_ready) begin
            if (oidx < 4) check_eq("stream_out", {24'd0, bus.log_out}, {24'd0, exps[oidx]});
            else check_eq("stream_extra_out", 32'd1, 32'd0);
            oidx++;
         end
         if (bus.in_valid && bus.in_ready) idx++;
         step();
      end
      check_eq("stream_in_count", idx, 32'd4);
      check_eq("stream_out_count", oidx, 32'd4);

      // reset with both stages full
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.x         = 8'h6D;
      step();
      bus.x = 8'h22;
      step();
      bus.in_valid = 1'b0;
      #1;
      check_eq("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      step();
      check_eq("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check_eq("mid_rst_log_out", {24'd0, bus.log_out}, 32'd0);
      check_eq("mid_rst_in_ready_cyc", {31'd0, bus.in_ready}, 32'd0);
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      check_eq("after_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      for (int k = 0; k < 4; k++) begin
         step();
         check_eq("no_stale_out", {31'd0, bus.out_valid}, 32'd0);
      end

      // randomized handshakes against the reference model
      n_rx = 0;
      sent = 0;
      cyc  = 0;
      while ((sent < 1000 || n_rx < 1000) && cyc < 20000) begin
         bus.in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
         bus.x         = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (bus.in_valid && bus.in_ready) sent++;
         step();
         cyc++;
      end
      if (cyc >= 20000) check_eq("random_timeout", 32'd1, 32'd0);
      check_eq("random_rx_count", n_rx, 32'd1000);
      check_eq("random_queue_empty", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/minsoo_mitchell_encoder_k.md
MINSOO_MITCHELL_ENCODER_K -- requirements
Module: minsoo_mitchell_encoder_k

Interface
REQ-001 SHALL have parameter N, default 8, linear operand width in bits.
REQ-002 SHALL have parameter LOG_N, default 3, equal to log2(N).
REQ-003 SHALL have parameter K, default 5, mantissa width in bits; 1 <= K.
REQ-004 SHALL have port clk, input, 1, single clock, rising-edge active.
REQ-005 SHALL have port rst_n, input, 1, reset: synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, operand x valid this cycle.
REQ-007 SHALL have port in_ready, output, 1, block accepts operand this cycle.
REQ-008 SHALL have port x, input, N, unsigned linear operand.
REQ-009 SHALL have port out_valid, output, 1, log_out/zero valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-011 SHALL have port log_out, output, LOG_N+K, Mitchell log {charac[LOG_N-1:0], mantissa[K-1:0]}.
REQ-012 SHALL have port zero, output, 1, operand was 0 (log undefined).

Function
REQ-013 SHALL transfer an input only on a cycle where in_valid and in_ready are both 1; an output transfer only where out_valid and out_ready are both 1.
REQ-014 SHALL be a 2-stage pipeline: stage 1 registers the operand, leading-one position and zero flag; stage 2 registers log_out and zero.
REQ-015 SHALL present a result on out_valid exactly 2 cycles after its input transfer when out_ready is held 1.
REQ-016 SHALL sustain one transfer per cycle with out_ready held 1 (in_ready stays 1).
REQ-017 SHALL compute charac = index of the most significant 1 of x (0..N-1).
REQ-018 SHALL compute mantissa = the bits of x below the leading one, MSB-aligned to mantissa[K-1], truncated (no rounding) to K bits, zero-filled at the LSB end when fewer than K bits exist.
REQ-019 SHALL, for x = 0, output zero = 1 and log_out = 0; zero = 0 for all nonzero x.
REQ-020 SHALL drive in_ready = !s1_valid OR stage 2 can advance; stage 2 advances when !out_valid OR out_ready.
REQ-021 SHALL hold log_out, zero and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-022 SHALL hold stage 1 contents while stage 2 is stalled; no operand dropped or duplicated under any in_valid/out_ready pattern.
REQ-023 SHALL, on a cycle with simultaneous input and output transfers while full, shift both stages in that cycle without bubble.
REQ-024 SHALL preserve operand order; results emerge in input-transfer order.
REQ-025 SHALL ignore x while in_valid = 0 or in_ready = 0.

Reset
REQ-026 SHALL, while rst_n = 0 at a rising clk edge, clear s1_valid and out_valid to 0, log_out to 0, zero to 0.
REQ-027 SHALL drive in_ready = 0 during a reset cycle and 1 on the first cycle after rst_n returns high.
REQ-028 SHALL discard any in-flight operands when reset asserts mid-operation; no result for them appears after reset.

Verification (N=8, LOG_N=3, K=5)
REQ-029 SHALL cover: x=8'b0110_1101 accepted at cycle t, out_ready=1 -> cycle t+2 out_valid=1, log_out=8'b110_10110, zero=0.
REQ-030 SHALL cover: x=1 -> log_out=8'b000_00000, zero=0; x=8'hFF -> log_out=8'b111_11111; x=8'b0000_0110 -> log_out=8'b010_10000.
REQ-031 SHALL cover: x=0 -> zero=1, log_out=0.
REQ-032 SHALL cover: stream x=3,5,9,17 back-to-back, out_ready low for 3 cycles after first result -> in_ready drops once both stages full, results 001_10000, 010_01000, 011_00100, 100_00010 emitted in order, none lost or repeated, outputs stable while stalled.
REQ-033 SHALL cover: random in_valid/out_ready toggling over 1000 operands against a reference model -> exact match, order preserved.
REQ-034 SHALL cover: rst_n low for 1 cycle with both stages full -> out_valid=0, in_ready=0 that cycle, in_ready=1 next cycle, no stale result afterward.
